// File: rtl/render_shape_engine.sv
// Scanline rasteriser for tangram pieces: square, four right triangles and a parallelogram.
// Latches one request, walks its rows top-down and emits one (x,y) pixel per enabled cycle.
module render_shape_engine #(
   parameter int CORDW = 10,
   parameter int DATAW = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [DATAW-1:0] ty,
   input  logic [CORDW-1:0] x0,
   input  logic [CORDW-1:0] y0,
   input  logic [DATAW-1:0] size,
   input  logic             oe,
   output logic [CORDW-1:0] x,
   output logic [CORDW-1:0] y,
   output logic             drawing,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [2:0]       dbg_state
);

   typedef enum logic [2:0] {IDLE, INIT, DRAW, NEXT_ROW, DONE} state_t;

   state_t           state;
   logic [2:0]       ty_q;
   logic [CORDW-1:0] x0_q, y0_q, n_q;
   logic [CORDW-1:0] row, col;
   logic [CORDW-1:0] n_m1, last_col;
   logic [CORDW-1:0] size_n;
   logic             ty_ok;
   logic             unused_size_hi;

   assign size_n         = size[CORDW-1:0];
   assign unused_size_hi = ^size[DATAW-1:CORDW];
   assign ty_ok          = (ty < DATAW'(6));
   assign n_m1           = n_q - CORDW'(1);
   assign dbg_state      = state;

   // Handshake: a pixel (x,y) transfers on every cycle drawing is high; oe acts as the
   // ready and the walk only advances on such a cycle, otherwise x, y and state hold.
   assign drawing = (state == DRAW) && oe;

   // Left edge of row k; all sums wrap modulo 2^CORDW.
   function automatic logic [CORDW-1:0] span_s(input logic [CORDW-1:0] k);
      case (ty_q)
         3'd2:    span_s = x0_q + n_m1 - k;
         3'd4,
         3'd5:    span_s = x0_q + k;
         default: span_s = x0_q;
      endcase
   endfunction

   // Column index of the last pixel in the current row (row length minus one).
   always_comb begin
      last_col = n_m1;
      case (ty_q)
         3'd1, 3'd2: last_col = row;
         3'd3, 3'd4: last_col = n_m1 - row;
         default:    last_col = n_m1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         x     <= '0;
         y     <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         err   <= 1'b0;
         row   <= '0;
         col   <= '0;
         ty_q  <= '0;
         x0_q  <= '0;
         y0_q  <= '0;
         n_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  ty_q <= ty[2:0];
                  x0_q <= x0;
                  y0_q <= y0;
                  n_q  <= size_n;
                  if (!ty_ok || size_n == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                     err   <= !ty_ok;
                  end else begin
                     state <= INIT;
                     busy  <= 1'b1;
                  end
               end
            end
            INIT: begin
               row   <= '0;
               col   <= '0;
               x     <= span_s('0);
               y     <= y0_q;
               state <= DRAW;
            end
            DRAW: begin
               if (oe) begin
                  if (col != last_col) begin
                     col <= col + CORDW'(1);
                     x   <= x + CORDW'(1);
                  end else if (row == n_m1) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     state <= NEXT_ROW;
                  end
               end
            end
            NEXT_ROW: begin
               row   <= row + CORDW'(1);
               col   <= '0;
               y     <= y + CORDW'(1);
               x     <= span_s(row + CORDW'(1));
               state <= DRAW;
            end
            DONE: begin
               done  <= 1'b0;
               err   <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_render_shape_engine.sv
// Bench for render_shape_engine: directed shapes from the shape table plus randomized
// requests, checked cycle by cycle against a pixel/event schedule built from the shape rules.
module tb_render_shape_engine;

   localparam int CORDW = 10;
   localparam int DATAW = 12;
   localparam int MASK  = (1 << CORDW) - 1;
   localparam int K_PIX = 0, K_INIT = 1, K_GAP = 2, K_DONE = 3;

   logic             clk = 1'b0;
   logic             rst, start, oe;
   logic [DATAW-1:0] ty, size;
   logic [CORDW-1:0] x0, y0;
   logic [CORDW-1:0] x, y;
   logic             drawing, busy, done, err;
   logic [2:0]       dbg_state;

   int total = 0;
   int bad   = 0;

   logic [31:0] exp_q[$];

   render_shape_engine #(.CORDW(CORDW), .DATAW(DATAW)) dut (
      .clk(clk), .rst(rst), .start(start), .ty(ty), .x0(x0), .y0(y0), .size(size), .oe(oe),
      .x(x), .y(y), .drawing(drawing), .busy(busy), .done(done), .err(err),
      .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ent(input int kind, input int xv, input int yv);
      logic [31:0] e;
      e = '0;
      e[25:24] = kind[1:0];
      e[19:10] = yv[9:0];
      e[9:0]   = xv[9:0];
      return e;
   endfunction

   // Expected cycle schedule: INIT, the pixels of each row with a gap between rows, DONE.
   task automatic build(input int t, input int xa, input int ya, input int n);
      int s, e;
      exp_q.delete();
      if (t >= 6 || n == 0) begin
         exp_q.push_back(ent(K_DONE, 0, 0));
         return;
      end
      exp_q.push_back(ent(K_INIT, 0, 0));
      for (int k = 0; k < n; k++) begin
         case (t)
            0:       begin s = xa;         e = xa + n - 1;     end
            1:       begin s = xa;         e = xa + k;         end
            2:       begin s = xa + n-1-k; e = xa + n - 1;     end
            3:       begin s = xa;         e = xa + n - 1 - k; end
            4:       begin s = xa + k;     e = xa + n - 1;     end
            default: begin s = xa + k;     e = xa + k + n - 1; end
         endcase
         for (int xi = s; xi <= e; xi++)
            exp_q.push_back(ent(K_PIX, xi & MASK, (ya + k) & MASK));
         if (k < n - 1) exp_q.push_back(ent(K_GAP, 0, 0));
      end
      exp_q.push_back(ent(K_DONE, 0, 0));
   endtask

   // oe_mode: 0 = held high, 1 = random, 2 = repeating 1,0,0,1 pattern.
   task automatic run_shape(input string name, input int t, input int xa, input int ya,
                            input int n, input int oe_mode, input bit spam, input int fixed_done);
      int          cyc, stalls, done_cyc, pcount, kind, exp_done;
      logic [31:0] e;
      logic [3:0]  pat;
      pat = 4'b1001;
      build(t, xa, ya, n);
      ty    = DATAW'(t);
      x0    = CORDW'(xa);
      y0    = CORDW'(ya);
      size  = {DATAW'($urandom_range(0, 3)) << CORDW} | DATAW'(n);
      start = 1'b1;
      oe    = 1'b1;
      #1;
      chk({name, "_idle_busy"}, busy, 0);
      tick();
      start    = 1'b0;
      cyc      = 1;
      stalls   = 0;
      done_cyc = -1;
      while (exp_q.size() > 0 && cyc < 5000) begin
         case (oe_mode)
            0:       oe = 1'b1;
            1:       oe = ($urandom_range(0, 3) != 0);
            default: oe = pat[cyc % 4];
         endcase
         start = spam ? 1'($urandom_range(0, 1)) : 1'b0;
         #1;
         e    = exp_q[0];
         kind = int'(e[25:24]);
         if (kind == K_DONE) begin
            chk({name, "_done"}, done, 1);
            chk({name, "_err"}, err, (t >= 6) ? 1 : 0);
            chk({name, "_done_busy"}, busy, 0);
            chk({name, "_done_drawing"}, drawing, 0);
            done_cyc = cyc;
            void'(exp_q.pop_front());
         end else if (kind == K_PIX) begin
            chk({name, "_pix_drawing"}, drawing, oe);
            chk({name, "_pix_x"}, x, e[9:0]);
            chk({name, "_pix_y"}, y, e[19:10]);
            chk({name, "_pix_busy"}, busy, 1);
            if (oe) void'(exp_q.pop_front());
            else stalls++;
         end else begin
            chk({name, "_ctl_drawing"}, drawing, 0);
            chk({name, "_ctl_busy"}, busy, 1);
            chk({name, "_ctl_done"}, done, 0);
            void'(exp_q.pop_front());
         end
         tick();
         cyc++;
      end
      start = 1'b0;
      chk({name, "_timeout"}, exp_q.size(), 0);
      if (t >= 6 || n == 0) exp_done = 1;
      else begin
         pcount   = (t == 0 || t == 5) ? n * n : n * (n + 1) / 2;
         exp_done = 2 + pcount + (n - 1) + stalls;
      end
      chk({name, "_done_cycle"}, done_cyc, exp_done);
      if (fixed_done >= 0) chk({name, "_done_fixed"}, done_cyc, fixed_done);
      #1;
      chk({name, "_after_done"}, done, 0);
      chk({name, "_after_busy"}, busy, 0);
      chk({name, "_after_err"}, err, 0);
   endtask

   initial begin
      int cnt, t, n, tyv;
      rst   = 1'b1;
      start = 1'b0;
      oe    = 1'b1;
      ty    = '0;
      x0    = '0;
      y0    = '0;
      size  = '0;
      tick();
      tick();
      chk("rst_x", x, 0);
      chk("rst_y", y, 0);
      chk("rst_drawing", drawing, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      rst = 1'b0;
      tick();

      run_shape("sq4", 0, 10, 20, 4, 0, 1'b0, 21);
      run_shape("tri_bl3", 1, 0, 0, 3, 0, 1'b0, 10);
      run_shape("tri_br3", 2, 0, 0, 3, 0, 1'b0, 10);
      run_shape("tri_tl3", 3, 0, 0, 3, 0, 1'b0, 10);
      run_shape("tri_tr3", 4, 0, 0, 3, 0, 1'b0, 10);
      run_shape("para_wrap", 5, 1022, 5, 2, 0, 1'b0, 7);
      run_shape("sq2_oe_pat", 0, 3, 4, 2, 2, 1'b0, -1);
      run_shape("invalid7", 7, 1, 1, 3, 0, 1'b0, 1);
      run_shape("size0", 0, 1, 1, 0, 0, 1'b0, 1);
      run_shape("sq4_spam", 0, 10, 20, 4, 0, 1'b1, 21);
      run_shape("one_px", 3, 1023, 1023, 1, 0, 1'b0, 3);

      // Reset while drawing the fifth pixel of a square.
      ty = 0; x0 = 10; y0 = 20; size = 4; start = 1'b1; oe = 1'b1;
      tick();
      start = 1'b0;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         if (drawing) cnt++;
         if (cnt == 5) break;
         tick();
      end
      chk("midrst_reach", cnt, 5);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_busy", busy, 0);
      chk("midrst_drawing", drawing, 0);
      chk("midrst_x", x, 0);
      chk("midrst_y", y, 0);
      chk("midrst_done", done, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("midrst_nodone", done, 0);
      end
      run_shape("sq4_after_rst", 0, 10, 20, 4, 0, 1'b0, 21);

      // Reset together with start drops the request.
      rst = 1'b1; start = 1'b1; ty = 0; size = 3;
      tick();
      rst = 1'b0; start = 1'b0;
      chk("rst_start_busy", busy, 0);
      tick();
      chk("rst_start_busy2", busy, 0);
      chk("rst_start_drawing", drawing, 0);

      for (int r = 0; r < 40; r++) begin
         t   = $urandom_range(0, 7);
         tyv = (t == 7) ? $urandom_range(6, 4095) : t;
         n   = $urandom_range(0, 9);
         run_shape("rand", tyv, $urandom_range(0, MASK), $urandom_range(0, MASK), n,
                   $urandom_range(0, 1), 1'($urandom_range(0, 1)), -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
